// File: rtl/regfile_bist.sv
// regfile_bist: two-pass write/read-back self test master for a 32x32 regfile.
module regfile_bist #(
  parameter int          NUM_REGS = 32,
  parameter logic [31:0] PATTERN  = 32'h00364908,
  parameter bit          R0_ZERO  = 1'b1,
  parameter int          ERR_W    = 8
) (
  input  logic             clock,
  input  logic             ctrl_reset,
  input  logic             start,
  output logic             ctrl_writeEn,
  output logic [4:0]       ctrl_writeReg,
  output logic [31:0]      data_writeReg,
  output logic [4:0]       ctrl_readRegA,
  output logic [4:0]       ctrl_readRegB,
  input  logic [31:0]      data_readRegA,
  input  logic [31:0]      data_readRegB,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] error_count,
  output logic [4:0]       fail_reg,
  output logic             fail_port
);
  typedef enum logic [2:0] {IDLE, WRITE, READ, CHECK, DONE} state_t;
  localparam logic [4:0] LAST = 5'(NUM_REGS - 1);
  state_t state, state_n;
  logic [4:0] idx, idx_n, freg_n;
  logic psel, psel_n, fport_n, mis_a, mis_b, rd;
  logic [ERR_W-1:0] err_n, sat;
  logic [ERR_W:0] sum;
  function automatic logic [31:0] pat(input logic [4:0] i, input logic p);
    return p ? ~(PATTERN ^ {27'b0, i}) : (PATTERN ^ {27'b0, i});
  endfunction
  function automatic logic [31:0] expv(input logic [4:0] i, input logic p);
    return (R0_ZERO && i == 5'd0) ? 32'h0 : pat(i, p);
  endfunction
  always_comb begin
    mis_a = state == CHECK && data_readRegA != expv(idx, psel);
    mis_b = state == CHECK && data_readRegB != expv(LAST - idx, psel);
    sum = {1'b0, error_count} + (ERR_W+1)'(mis_a) + (ERR_W+1)'(mis_b);
    sat = sum[ERR_W] ? '1 : sum[ERR_W-1:0];
  end
  always_comb begin
    state_n = state;
    idx_n = idx;
    psel_n = psel;
    err_n = error_count;
    freg_n = fail_reg;
    fport_n = fail_port;
    case (state)
      IDLE, DONE: if (start) begin
        state_n = WRITE;
        idx_n = '0;
        psel_n = 1'b0;
        err_n = '0;
        freg_n = '0;
        fport_n = 1'b0;
      end
      WRITE: begin
        idx_n = idx == LAST ? 5'd0 : idx + 5'd1;
        state_n = idx == LAST ? READ : WRITE;
      end
      READ: state_n = CHECK;
      CHECK: begin
        err_n = sat;
        // a zero count means nothing has failed yet since start; A wins a tie
        if (error_count == '0 && (mis_a || mis_b)) begin
          freg_n = mis_a ? idx : LAST - idx;
          fport_n = !mis_a;
        end
        if (idx != LAST) begin
          idx_n = idx + 5'd1;
          state_n = READ;
        end else if (!psel) begin
          psel_n = 1'b1;
          idx_n = '0;
          state_n = WRITE;
        end else state_n = DONE;
      end
      default: state_n = IDLE;
    endcase
    rd = state_n == READ || state_n == CHECK;
  end
  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      state <= IDLE;
      idx <= '0;
      psel <= 1'b0;
      error_count <= '0;
      fail_reg <= '0;
      fail_port <= 1'b0;
      ctrl_writeEn <= 1'b0;
      ctrl_writeReg <= '0;
      data_writeReg <= '0;
      ctrl_readRegA <= '0;
      ctrl_readRegB <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      pass <= 1'b0;
    end else begin
      state <= state_n;
      idx <= idx_n;
      psel <= psel_n;
      error_count <= err_n;
      fail_reg <= freg_n;
      fail_port <= fport_n;
      ctrl_writeEn <= state_n == WRITE;
      ctrl_writeReg <= state_n == WRITE ? idx_n : 5'd0;
      data_writeReg <= state_n == WRITE ? pat(idx_n, psel_n) : 32'h0;
      ctrl_readRegA <= rd ? idx_n : 5'd0;
      ctrl_readRegB <= rd ? LAST - idx_n : 5'd0;
      busy <= state_n == WRITE || state_n == READ || state_n == CHECK;
      done <= state_n == DONE;
      pass <= state_n == DONE && err_n == '0;
    end
  end
endmodule

// File: tb/tb_regfile_bist.sv
// tb_regfile_bist: random and directed checks of two BIST instances against a run-level model.
module tb_regfile_bist;
  logic clock = 1'b0, ctrl_reset = 1'b1, start = 1'b0;
  int mode = 0;
  logic we0, we1, busy0, busy1, done0, done1, pass0, pass1, fp0, fp1;
  logic [4:0] wr0, wr1, ra0, ra1, rb0, rb1, fr0, fr1, err0;
  logic [7:0] err1;
  logic [31:0] wd0, wd1, da0, da1, db0, db1;
  logic [31:0] rf0 [32];
  logic [31:0] rf1 [32];
  int total = 0, bad = 0;
  bit armed = 0, act = 0, mdone = 0;
  int k = 0;
  int merr [2] = '{0, 0};
  int mfr [2] = '{0, 0};
  int mfp [2] = '{0, 0};

  always #5 clock = ~clock;

  regfile_bist #(.R0_ZERO(1'b0), .ERR_W(5)) dut0 (
    .clock(clock), .ctrl_reset(ctrl_reset), .start(start),
    .ctrl_writeEn(we0), .ctrl_writeReg(wr0), .data_writeReg(wd0),
    .ctrl_readRegA(ra0), .ctrl_readRegB(rb0), .data_readRegA(da0), .data_readRegB(db0),
    .busy(busy0), .done(done0), .pass(pass0), .error_count(err0),
    .fail_reg(fr0), .fail_port(fp0));
  regfile_bist dut1 (
    .clock(clock), .ctrl_reset(ctrl_reset), .start(start),
    .ctrl_writeEn(we1), .ctrl_writeReg(wr1), .data_writeReg(wd1),
    .ctrl_readRegA(ra1), .ctrl_readRegB(rb1), .data_readRegA(da1), .data_readRegB(db1),
    .busy(busy1), .done(done1), .pass(pass1), .error_count(err1),
    .fail_reg(fr1), .fail_port(fp1));

  // regfile with r0 hardwired; mode 1 sticks reg 7 bit 3 low, mode 2 forces port B to all ones
  function automatic logic [31:0] fault(input logic [31:0] v, input int a, input bit b, input int m);
    logic [31:0] r;
    r = (a == 0) ? 32'h0 : v;
    if (m == 1 && a == 7) r[3] = 1'b0;
    if (m == 2 && b) r = '1;
    return r;
  endfunction
  function automatic logic [31:0] pat(input int i, input int p);
    logic [31:0] v;
    v = 32'h00364908 ^ i;
    return p != 0 ? ~v : v;
  endfunction
  function automatic logic [31:0] expv(input int i, input int p, input int z);
    return (z != 0 && i == 0) ? 32'h0 : pat(i, p);
  endfunction

  always @(posedge clock) begin
    if (we0) rf0[wr0] <= wd0;
    if (we1) rf1[wr1] <= wd1;
  end
  assign da0 = fault(rf0[ra0], int'(ra0), 1'b0, mode);
  assign db0 = fault(rf0[rb0], int'(rb0), 1'b1, mode);
  assign da1 = fault(rf1[ra1], int'(ra1), 1'b0, mode);
  assign db1 = fault(rf1[rb1], int'(rb1), 1'b1, mode);

  task automatic chk(input int d, input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL d%0d_%s got=%h want=%h t=%0t", d, n, a, e, $time);
    end
  endtask

  // run model: cycle k of a run is write (k%96<32) or a read/check pair, 96 cycles per pass
  task automatic model_step();
    int p, r, i, j, mx;
    bit ma, mb;
    if (ctrl_reset) begin
      act = 0;
      mdone = 0;
      merr = '{0, 0};
      mfr = '{0, 0};
      mfp = '{0, 0};
    end else if (act) begin
      p = k / 96;
      r = k % 96;
      if (r >= 32 && (r - 32) % 2 == 1) begin
        i = (r - 32) / 2;
        j = 31 - i;
        for (int d = 0; d < 2; d++) begin
          ma = fault(pat(i, p), i, 1'b0, mode) != expv(i, p, d);
          mb = fault(pat(j, p), j, 1'b1, mode) != expv(j, p, d);
          if (merr[d] == 0 && (ma || mb)) begin
            mfr[d] = ma ? i : j;
            mfp[d] = ma ? 0 : 1;
          end
          mx = d != 0 ? 255 : 31;
          merr[d] = merr[d] + int'(ma) + int'(mb);
          if (merr[d] > mx) merr[d] = mx;
        end
      end
      k++;
      if (k == 192) begin
        act = 0;
        mdone = 1;
      end
    end else if (start) begin
      act = 1;
      k = 0;
      mdone = 0;
      merr = '{0, 0};
      mfr = '{0, 0};
      mfp = '{0, 0};
    end
  endtask
  initial forever begin
    @(posedge clock);
    model_step();
  end

  task automatic cmp(input int d, input logic we, input logic [4:0] wr, input logic [31:0] wd,
                     input logic [4:0] ra, input logic [4:0] rb, input logic bz, input logic dn,
                     input logic ps, input logic [7:0] er, input logic [4:0] fr, input logic fp);
    int p, r, era;
    bit ewe, erd;
    p = k / 96;
    r = k % 96;
    ewe = act && r < 32;
    erd = act && r >= 32;
    era = erd ? (r - 32) / 2 : 0;
    chk(d, "we", we, ewe);
    chk(d, "wreg", wr, ewe ? r : 0);
    chk(d, "wdata", wd, ewe ? pat(r, p) : 32'h0);
    chk(d, "rega", ra, era);
    chk(d, "regb", rb, erd ? 31 - era : 0);
    chk(d, "busy", bz, act);
    chk(d, "done", dn, mdone);
    chk(d, "pass", ps, mdone && merr[d] == 0);
    chk(d, "errs", er, merr[d]);
    chk(d, "freg", fr, mfr[d]);
    chk(d, "fport", fp, mfp[d]);
  endtask
  always @(negedge clock) if (armed) begin
    cmp(0, we0, wr0, wd0, ra0, rb0, busy0, done0, pass0, {3'b0, err0}, fr0, fp0);
    cmp(1, we1, wr1, wd1, ra1, rb1, busy1, done1, pass1, err1, fr1, fp1);
  end

  task automatic tick();
    @(negedge clock);
  endtask
  task automatic run_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    repeat (2) tick();
    armed = 1;
    chk(1, "rst_ctl", {we1, busy1, done1, pass1, fp1, err1, fr1, wr1}, 0);
    chk(1, "rst_data", wd1, 0);
    chk(1, "rst_raddr", {ra1, rb1}, 0);
    chk(0, "rst_ctl", {we0, busy0, done0, pass0, fp0, err0, fr0, wr0}, 0);
    ctrl_reset = 1'b0;
    tick();
    run_start();
    chk(1, "first_we", we1, 1);
    chk(1, "first_wreg", wr1, 0);
    chk(1, "first_wdata", wd1, 32'h00364908);
    repeat (101) tick();
    chk(1, "p1_wreg", wr1, 5);
    chk(1, "p1_wdata", wd1, 32'hFFC9B6F2);
    repeat (90) tick();
    chk(1, "busy_191", {busy1, done1}, 2'b10);
    tick();
    chk(1, "good_done", {busy1, done1, pass1}, 3'b011);
    chk(1, "good_errs", err1, 0);
    chk(0, "r0_errs", err0, 4);
    chk(0, "r0_fail", {pass0, fr0, fp0}, {1'b0, 5'd0, 1'b0});
    mode = 1;
    run_start();
    repeat (192) tick();
    chk(1, "stuck_errs", err1, 2);
    chk(1, "stuck_fail", {done1, pass1, fr1, fp1}, {1'b1, 1'b0, 5'd7, 1'b0});
    mode = 2;
    run_start();
    repeat (192) tick();
    chk(1, "portb_errs", err1, 64);
    chk(1, "portb_fail", {fr1, fp1}, {5'd31, 1'b1});
    chk(0, "sat_errs", err0, 5'h1f);
    repeat (3) tick();
    chk(0, "sat_hold", err0, 5'h1f);
    mode = 0;
    run_start();
    repeat (10) tick();
    ctrl_reset = 1'b1;
    tick();
    ctrl_reset = 1'b0;
    chk(1, "midrst", {we1, busy1, done1, err1}, 0);
    chk(0, "midrst", {we0, busy0, done0, err0}, 0);
    run_start();
    repeat (192) tick();
    chk(1, "after_rst", {done1, pass1}, 2'b11);
    run_start();
    repeat (50) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (140) tick();
    chk(1, "ign_191", done1, 0);
    tick();
    chk(1, "ign_192", done1, 1);
    run_start();
    chk(1, "restart", {busy1, done1}, 2'b10);
    repeat (192) tick();
    chk(1, "rerun", {done1, pass1}, 2'b11);
    start = 1'b1;
    tick();
    repeat (192) tick();
    chk(1, "held_done", done1, 1);
    tick();
    chk(1, "held_again", {busy1, done1}, 2'b10);
    start = 1'b0;
    repeat (192) tick();
    chk(1, "held_end", done1, 1);
    ctrl_reset = 1'b1;
    start = 1'b1;
    tick();
    ctrl_reset = 1'b0;
    start = 1'b0;
    chk(1, "rst_prio", {busy1, done1}, 0);
    for (int it = 0; it < 20; it++) begin
      ctrl_reset = 1'b1;
      tick();
      ctrl_reset = 1'b0;
      mode = int'($urandom_range(0, 2));
      repeat (260) begin
        start = $urandom_range(0, 15) == 0;
        ctrl_reset = $urandom_range(0, 299) == 0;
        tick();
      end
      start = 1'b0;
      ctrl_reset = 1'b0;
    end
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
